// File: rtl/common_pkg.sv
// Shared types for the vector issue arbiter: instruction word, wavefront width
// and the in-order completion tag.
package common_pkg;
  localparam int THREADS_PER_WAVEFRONT   = 32;
  localparam int VEC_ARB_NUM_REQ_DEFAULT = 4;
  localparam int VEC_ARB_ID_W            = $clog2(VEC_ARB_NUM_REQ_DEFAULT);

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  vd, vs1, vs2;
    logic [10:0] imm;
  } vector_inst_t;

  typedef struct packed {
    logic                    skip;
    logic [VEC_ARB_ID_W-1:0] id;
  } vec_arb_tag_t;
endpackage

// File: rtl/vector_issue_arbiter_if.sv
// Requester / execute-unit handshake bundle. The arbiter uses the slave view,
// the surrounding pipeline (or a bench) the master view.
interface vector_issue_arbiter_if
  import common_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]                            req_valid;
  logic [NUM_REQ-1:0]                            req_ready;
  vector_inst_t [NUM_REQ-1:0]                    req_inst;
  logic [NUM_REQ-1:0][THREADS_PER_WAVEFRONT-1:0] req_exec;
  logic                                          vec_issue;
  vector_inst_t                                  vec_inst;
  logic [THREADS_PER_WAVEFRONT-1:0]              vec_exec;
  logic                                          vec_busy;
  logic                                          vec_out_valid;
  logic                                          vec_out_ready;
  logic [NUM_REQ-1:0]                            rsp_valid;
  logic [NUM_REQ-1:0]                            rsp_ready;

  modport slave (
    input  req_valid, req_inst, req_exec, vec_busy, vec_out_valid, rsp_ready,
    output req_ready, vec_issue, vec_inst, vec_exec, vec_out_ready, rsp_valid
  );

  modport master (
    output req_valid, req_inst, req_exec, vec_busy, vec_out_valid, rsp_ready,
    input  req_ready, vec_issue, vec_inst, vec_exec, vec_out_ready, rsp_valid
  );
endinterface

// File: rtl/vec_arb_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding instruction.
// Simultaneous push and pop are both performed.
module vec_arb_tag_fifo
  import common_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  vec_arb_tag_t i_push_tag,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output vec_arb_tag_t o_head
);
  localparam int PTR_W = $clog2(TAG_DEPTH);

  vec_arb_tag_t     r_mem [TAG_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(TAG_DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_tag;
  end
endmodule

// File: rtl/vector_issue_arbiter.sv
// Round-robin issue arbiter sharing one vector execute unit between wavefront
// requesters, with in-order completion routing. Option: VEC_ARB_SKIP_EMPTY_EXEC_EN.
module vector_issue_arbiter
  import common_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  vector_issue_arbiter_if.slave  bus,
  output logic                   idle,
  output logic                   err_orphan
);
  logic [VEC_ARB_ID_W-1:0]          r_rr_ptr;
  logic                             r_vec_issue;
  vector_inst_t                     r_vec_inst;
  logic [THREADS_PER_WAVEFRONT-1:0] r_vec_exec;
  logic                             r_err_orphan;

  logic [VEC_ARB_ID_W-1:0] w_cand;
  logic [VEC_ARB_ID_W-1:0] w_grant_id;
  logic                    w_grant_vld;
  logic                    w_grant_skip;
  logic                    w_issue_ok;
  logic                    w_accept;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_pop;
  logic                    w_vec_out_ready;
  vec_arb_tag_t            w_head;
  vec_arb_tag_t            w_push_tag;
  logic [NUM_REQ-1:0]      w_head_onehot;
  logic [NUM_REQ-1:0]      w_rsp_valid;

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = VEC_ARB_ID_W'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_grant_vld && bus.req_valid[w_cand]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = w_cand;
      end
    end
  end

`ifdef VEC_ARB_SKIP_EMPTY_EXEC_EN
  assign w_grant_skip = (bus.req_exec[w_grant_id] == '0);
`else
  assign w_grant_skip = 1'b0;
`endif

  // vec_busy lags the issue pulse by a cycle, so the pulse itself blocks issue.
  assign w_issue_ok    = !bus.vec_busy && !r_vec_issue && !w_fifo_full;
  assign w_accept      = w_grant_vld && (w_grant_skip ? !w_fifo_full : w_issue_ok);
  assign bus.req_ready = w_accept ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign w_push_tag    = '{skip: w_grant_skip, id: w_grant_id};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_vec_issue  <= 1'b0;
      r_vec_inst   <= '0;
      r_vec_exec   <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_vec_issue <= w_accept && !w_grant_skip;
      if (w_accept) begin
        r_rr_ptr <= (w_grant_id == VEC_ARB_ID_W'(NUM_REQ - 1)) ? '0
                                                                : w_grant_id + VEC_ARB_ID_W'(1);
        if (!w_grant_skip) begin
          r_vec_inst <= bus.req_inst[w_grant_id];
          r_vec_exec <= bus.req_exec[w_grant_id];
        end
      end
      if (bus.vec_out_valid && w_fifo_empty) r_err_orphan <= 1'b1;
    end
  end

  vec_arb_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_accept),
    .i_push_tag (w_push_tag),
    .i_pop      (w_pop),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_head     (w_head)
  );

  assign w_head_onehot = NUM_REQ'(1) << w_head.id;

  // Empty FIFO drains stray results; a skip head completes without the execute unit.
  always_comb begin
    w_rsp_valid     = '0;
    w_vec_out_ready = 1'b0;
    w_pop           = 1'b0;
    if (w_fifo_empty) begin
      w_vec_out_ready = 1'b1;
    end else if (w_head.skip) begin
`ifdef VEC_ARB_SKIP_EMPTY_EXEC_EN
      w_rsp_valid = w_head_onehot;
      w_pop       = bus.rsp_ready[w_head.id];
`endif
    end else begin
      w_rsp_valid     = w_head_onehot & {NUM_REQ{bus.vec_out_valid}};
      w_vec_out_ready = bus.rsp_ready[w_head.id];
      w_pop           = bus.vec_out_valid && w_vec_out_ready;
    end
  end

  assign bus.rsp_valid     = w_rsp_valid;
  assign bus.vec_out_ready = w_vec_out_ready;
  assign bus.vec_issue     = r_vec_issue;
  assign bus.vec_inst      = r_vec_inst;
  assign bus.vec_exec      = r_vec_exec;
  assign idle              = w_fifo_empty && !r_vec_issue;
  assign err_orphan        = r_err_orphan;
endmodule

// File: tb/tb_vector_issue_arbiter.sv
// Directed bench for vector_issue_arbiter with an expected-owner scoreboard.
module tb_vector_issue_arbiter;
  import common_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle;
  logic err_orphan;

  int n_checks = 0;
  int n_err    = 0;
  int sb[$];

  vector_inst_t                     inst_tb [4];
  logic [THREADS_PER_WAVEFRONT-1:0] exec_tb [4];

  vector_issue_arbiter_if #(.NUM_REQ(4)) bus ();

  vector_issue_arbiter #(
    .NUM_REQ   (4),
    .TAG_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .idle       (idle),
    .err_orphan (err_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

`ifndef VEC_ARB_SKIP_EMPTY_EXEC_EN
  always @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 4; r++) begin
        assert (!(bus.req_valid[r] && bus.req_exec[r] == '0))
        else begin
          n_err++;
          $error("FAIL zero_exec_request req=%0d observed=valid expected=nonzero exec", r);
        end
      end
    end
  end
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    bus.req_valid     = '0;
    bus.vec_busy      = 1'b0;
    bus.vec_out_valid = 1'b0;
    bus.rsp_ready     = '1;
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  // Expect requester r granted this cycle; returns in the issue-pulse cycle.
  task automatic accept_exp(input int r);
    settle();
    chk("req_ready_grant", bus.req_ready, 64'(1) << r);
    sb.push_back(r);
    tick();
    chk("vec_issue_pulse", bus.vec_issue, 1);
    chk("vec_inst", bus.vec_inst, inst_tb[r]);
    chk("vec_exec", bus.vec_exec, exec_tb[r]);
    chk("req_ready_blocked_by_issue", bus.req_ready, 0);
  endtask

  task automatic complete();
    int exp_id;
    bus.vec_out_valid = 1'b1;
    settle();
    if (sb.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard_empty observed=completion expected=none");
    end else begin
      exp_id = sb.pop_front();
      chk("rsp_valid_route", bus.rsp_valid, 64'(1) << exp_id);
      chk("vec_out_ready", bus.vec_out_ready, 1);
    end
    tick();
    bus.vec_out_valid = 1'b0;
  endtask

  initial begin
    int order2 [5] = '{0, 1, 2, 3, 0};
    int order4 [4] = '{3, 0, 1, 2};

    for (int r = 0; r < 4; r++) begin
      inst_tb[r]       = vector_inst_t'($urandom);
      exec_tb[r]       = $urandom | 32'h1;
      bus.req_inst[r]  = inst_tb[r];
      bus.req_exec[r]  = exec_tb[r];
    end
    do_reset();

    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_req_ready", bus.req_ready, 0);
    chk("reset_idle", idle, 1);
    chk("reset_vec_issue", bus.vec_issue, 0);
    chk("reset_vec_inst", bus.vec_inst, 0);
    chk("reset_err_orphan", err_orphan, 0);

    // Single request from requester 1
    bus.req_valid = 4'b0010;
    accept_exp(1);
    bus.req_valid = '0;
    settle();
    chk("single_idle_during_issue", idle, 0);
    tick();
    chk("single_issue_one_cycle", bus.vec_issue, 0);
    chk("single_idle_outstanding", idle, 0);
    complete();
    settle();
    chk("single_idle_after", idle, 1);

    // All requesting, completion during each issue pulse
    do_reset();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      accept_exp(order2[i]);
      complete();
    end
    bus.req_valid = '0;

    // Execute unit busy for five cycles (rr_ptr now 1)
    bus.req_valid = 4'b0100;
    bus.vec_busy  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("busy_req_ready", bus.req_ready, 0);
      chk("busy_vec_issue", bus.vec_issue, 0);
      tick();
    end
    bus.vec_busy = 1'b0;
    accept_exp(2);
    bus.req_valid = '0;
    complete();

    // Fill the tag FIFO (rr_ptr now 3)
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      accept_exp(order4[i]);
      tick();
    end
    settle();
    chk("full_req_ready", bus.req_ready, 0);
    chk("full_idle", idle, 0);
    bus.rsp_ready     = '0;
    bus.vec_out_valid = 1'b1;
    settle();
    chk("held_rsp_valid", bus.rsp_valid, 64'(1) << sb[0]);
    chk("held_vec_out_ready", bus.vec_out_ready, 0);
    tick();
    chk("held_no_pop_rsp_valid", bus.rsp_valid, 64'(1) << sb[0]);
    chk("held_still_full", bus.req_ready, 0);
    bus.rsp_ready = '1;
    complete();
    accept_exp(3);
    bus.req_valid = '0;
    for (int i = 0; i < 4; i++) complete();
    settle();
    chk("drain_idle", idle, 1);

    // Orphan result after reset
    do_reset();
    bus.vec_out_valid = 1'b1;
    settle();
    chk("orphan_vec_out_ready", bus.vec_out_ready, 1);
    chk("orphan_rsp_valid", bus.rsp_valid, 0);
    tick();
    bus.vec_out_valid = 1'b0;
    settle();
    chk("orphan_set", err_orphan, 1);
    tick();
    tick();
    tick();
    chk("orphan_sticky", err_orphan, 1);
    do_reset();
    chk("orphan_cleared_by_reset", err_orphan, 0);
    chk("orphan_reset_idle", idle, 1);

`ifdef VEC_ARB_SKIP_EMPTY_EXEC_EN
    bus.req_valid = 4'b0001;
    accept_exp(0);
    bus.req_valid   = 4'b0010;
    bus.req_exec[1] = '0;
    settle();
    chk("skip_accept_during_issue", bus.req_ready, 4'b0010);
    sb.push_back(1);
    tick();
    bus.req_valid = '0;
    settle();
    chk("skip_no_issue", bus.vec_issue, 0);
    chk("skip_waits_behind_head", bus.rsp_valid, 0);
    complete();
    settle();
    chk("skip_rsp_valid", bus.rsp_valid, 64'(1) << sb[0]);
    chk("skip_vec_out_ready", bus.vec_out_ready, 0);
    void'(sb.pop_front());
    tick();
    chk("skip_idle_after", idle, 1);
    bus.req_exec[1] = exec_tb[1];
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
